// File: rtl/dff_share_pkg.sv
// Shared types and width helpers for the shared-register arbiter.
package dff_share_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StOwned
  } state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned hold_width(int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(N)) begin
        idx = idx - (IDX_W + 1)'(N);
      end
      if (!any && req[idx[IDX_W-1:0]]) begin
        any  = 1'b1;
        pick = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write controller sharing one WIDTH-bit register among N requesters.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned IDX_W   = idx_width(N),
  localparam int unsigned HOLD_W  = hold_width(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data,
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     q,
  output logic [IDX_W-1:0]     q_owner,
  output logic                 q_valid
);

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [IDX_W-1:0]   q_owner_q, q_owner_d;
  logic               q_valid_q, q_valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [IDX_W-1:0]   pick;
  logic               any;
  logic [WIDTH-1:0]   data_arr [N];

  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign data_arr[i] = data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      q_q       <= '0;
      q_owner_q <= '0;
      q_valid_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_owner_q <= q_owner_d;
      q_valid_q <= q_valid_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    q_d       = q_q;
    q_owner_d = q_owner_q;
    q_valid_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          gnt_d   = N'(1) << pick;
          owner_d = pick;
          hold_d  = '0;
          state_d = StOwned;
        end
      end
      StOwned: begin
        if (req[owner_q]) begin
          q_d       = data_arr[owner_q];
          q_owner_d = owner_q;
          q_valid_d = 1'b1;
          hold_d    = hold_q + HOLD_W'(1);
        end
        // Release on withdraw, or on the load that uses up the hold budget.
        if (!req[owner_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt     = gnt_q;
    q       = q_q;
    q_owner = q_owner_q;
    q_valid = q_valid_q;
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter with a load scoreboard checked by an independent monitor.
module tb_dff_share_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDX_W    = 2;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   data;
  logic [N-1:0]         gnt;
  logic [WIDTH-1:0]     q;
  logic [IDX_W-1:0]     q_owner;
  logic                 q_valid;

  int total;
  int bad;
  logic [IDX_W+WIDTH-1:0] exp_q [$];

  dff_share_arbiter #(
    .N        (N),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic push(input logic [IDX_W-1:0] owner, input logic [WIDTH-1:0] v);
    exp_q.push_back({owner, v});
  endtask

  // Monitor: every q_valid pulse must match the oldest expected load.
  always @(posedge clk) begin
    logic [IDX_W+WIDTH-1:0] e;
    #1;
    total++;
    if (!$onehot0(gnt)) begin
      bad++;
      $display("FAIL gnt_onehot: got %b expected at most one bit", gnt);
    end
    if (q_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load: got q=%0h owner=%0d expected no q_valid", q, q_owner);
      end else begin
        e = exp_q.pop_front();
        if ({q_owner, q} !== e) begin
          bad++;
          $display("FAIL load_value: got owner=%0d q=%0h expected owner=%0d q=%0h",
                   q_owner, q, e[IDX_W+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = '0;
    data  = '0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_owner", 32'(q_owner), 32'h0);
    chk("rst_valid", 32'(q_valid), 32'h0);
    reset = 1'b1;

    // Single requester, two loads, then drop.
    req = 4'b0010;
    set_data(1, 8'hA5);
    step();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_grant_no_load", 32'(q_valid), 32'h0);
    push(1, 8'hA5);
    step();
    push(1, 8'hA5);
    step();
    req = 4'b0000;
    step();
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    chk("t1_q", 32'(q), 32'hA5);
    chk("t1_owner", 32'(q_owner), 32'h1);

    // ptr=2 must select 3 over 1; then immediate withdraw.
    req = 4'b1010;
    step();
    chk("t6_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    chk("t6_gnt_drop", 32'(gnt), 32'h0);
    chk("t6_q_kept", 32'(q), 32'hA5);
    chk("t6_no_valid", 32'(q_valid), 32'h0);

    // ptr must have wrapped to 0: 0 wins over 2.
    req = 4'b0101;
    set_data(0, 8'h0F);
    step();
    chk("t6_ptr_wrap", 32'(gnt), 32'h1);
    req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      set_data(0, 8'(8'h10 + k));
      if (k != 4 && k != 9) push(0, 8'(8'h10 + k));
      step();
      if (k == 3) chk("t2_limit_release", 32'(gnt), 32'h0);
      if (k == 4) chk("t2_regrant", 32'(gnt), 32'h1);
    end
    req = 4'b0000;
    step();
    chk("t2_gnt_drop", 32'(gnt), 32'h0);

    // Non-owner isolation, then asynchronous reset mid-ownership.
    req = 4'b0100;
    set_data(2, 8'h3C);
    set_data(0, 8'hFF);
    step();
    chk("t4_gnt2", 32'(gnt), 32'h4);
    req = 4'b0101;
    push(2, 8'h3C);
    step();
    push(2, 8'h3C);
    step();
    chk("t4_q", 32'(q), 32'h3C);
    chk("t4_owner", 32'(q_owner), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'h0);
    chk("t5_async_q", 32'(q), 32'h0);
    chk("t5_async_valid", 32'(q_valid), 32'h0);
    chk("t5_async_owner", 32'(q_owner), 32'h0);
    step();
    reset = 1'b1;
    req   = 4'b1000;
    set_data(3, 8'h77);
    step();
    chk("t5_gnt3", 32'(gnt), 32'h8);
    push(3, 8'h77);
    step();
    req = 4'b0000;
    step();
    chk("t5_release", 32'(gnt), 32'h0);
    chk("t5_q", 32'(q), 32'h77);
    chk("t5_owner", 32'(q_owner), 32'h3);

    // Round robin with all requesting: order 0,1,2,3,0.
    for (int i = 0; i < int'(N); i++) set_data(i, 8'(8'hC0 + i));
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111;
      step();
      chk($sformatf("t3_order%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      push(2'(k % 4), 8'(8'hC0 + (k % 4)));
      step();
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      step();
      chk($sformatf("t3_release%0d", k), 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    step();
    step();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
